// File: rtl/game_phase_controller.sv
// Central Pac-Man sequencer: phases, lives, the power-pellet reversal timer and the ghost/pellet masks.
// All game state advances only on a single-Clk tick taken from the rising edge of the synchronised VGA_VS.
module game_phase_controller #(
    parameter int LIVES_INIT    = 2,
    parameter int READY_FRAMES  = 120,
    parameter int FRIGHT_FRAMES = 600,
    parameter int FRIGHT_WARN   = 120,
    parameter int DYING_FRAMES  = 90
) (
    input  logic       Clk,
    input  logic       Reset_h,
    input  logic       frame_vs,
    input  logic       start,
    input  logic [2:0] pellet_hit,
    input  logic [2:0] ghost_hit,
    input  logic       dots_cleared,
    output logic [2:0] phase,
    output logic [1:0] lives,
    output logic       reversal,
    output logic       fright_warn,
    output logic [9:0] fright_left,
    output logic [2:0] ghost_enable,
    output logic [2:0] pellet_on,
    output logic       freeze,
    output logic       respawn,
    output logic [1:0] ghost_eaten,
    output logic       eat_pulse,
    output logic       death,
    output logic       victory
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READY  = 3'd1,
        S_PLAY   = 3'd2,
        S_FRIGHT = 3'd3,
        S_DYING  = 3'd4,
        S_OVER   = 3'd5,
        S_WIN    = 3'd6
    } phase_t;

    localparam logic [1:0] L_INIT   = 2'(LIVES_INIT);
    localparam logic [9:0] T_READY  = 10'(READY_FRAMES);
    localparam logic [9:0] T_FRIGHT = 10'(FRIGHT_FRAMES);
    localparam logic [9:0] T_WARN   = 10'(FRIGHT_WARN);
    localparam logic [9:0] T_DYING  = 10'(DYING_FRAMES);

    phase_t     state, state_n;
    logic [9:0] timer, timer_n;
    logic [1:0] lives_n;
    logic [2:0] ghost_n, pellet_n;
    logic       respawn_n, eat_n, death_n, victory_n;
    logic [1:0] eaten_n;

    logic       vs_s1, vs_s2, vs_s3;
    logic       frame_tick;
    logic [2:0] ghost_live, pellet_live;
    logic [1:0] eaten_cnt;

    // Two flops bring VS into the Clk domain; the third only remembers the previous level for edge detection.
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_s3 <= 1'b0;
        end else begin
            vs_s1 <= frame_vs;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    assign frame_tick  = vs_s2 & ~vs_s3;
    assign ghost_live  = ghost_hit & ghost_enable;
    assign pellet_live = pellet_hit & pellet_on;
    assign eaten_cnt   = {1'b0, ghost_live[0]} + {1'b0, ghost_live[1]} + {1'b0, ghost_live[2]};

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            state        <= S_IDLE;
            timer        <= 10'd0;
            lives        <= L_INIT;
            ghost_enable <= 3'b111;
            pellet_on    <= 3'b111;
            respawn      <= 1'b0;
            eat_pulse    <= 1'b0;
            ghost_eaten  <= 2'd0;
            death        <= 1'b0;
            victory      <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            lives        <= lives_n;
            ghost_enable <= ghost_n;
            pellet_on    <= pellet_n;
            respawn      <= respawn_n;
            eat_pulse    <= eat_n;
            ghost_eaten  <= eaten_n;
            death        <= death_n;
            victory      <= victory_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        lives_n   = lives;
        ghost_n   = ghost_enable;
        pellet_n  = pellet_on;
        respawn_n = 1'b0;
        eat_n     = 1'b0;
        eaten_n   = 2'd0;
        death_n   = death;
        victory_n = victory;

        if (frame_tick) begin
            case (state)
                S_IDLE, S_OVER, S_WIN: begin
                    // A new game from any resting phase reloads everything and goes straight to READY.
                    if (start) begin
                        state_n   = S_READY;
                        timer_n   = T_READY;
                        lives_n   = L_INIT;
                        pellet_n  = 3'b111;
                        ghost_n   = 3'b111;
                        respawn_n = 1'b1;
                        death_n   = 1'b0;
                        victory_n = 1'b0;
                    end
                end
                S_READY: begin
                    if (timer == 10'd0) state_n = S_PLAY;
                    else                timer_n = timer - 10'd1;
                end
                S_PLAY: begin
                    if (dots_cleared) begin
                        state_n   = S_WIN;
                        victory_n = 1'b1;
                    end else if (|ghost_live) begin
                        state_n = S_DYING;
                        timer_n = T_DYING;
                    end else if (|pellet_live) begin
                        state_n  = S_FRIGHT;
                        timer_n  = T_FRIGHT;
                        pellet_n = pellet_on & ~pellet_live;
                    end
                end
                S_FRIGHT: begin
                    if (dots_cleared) begin
                        state_n   = S_WIN;
                        victory_n = 1'b1;
                    end else begin
                        if (|ghost_live) begin
                            ghost_n = ghost_enable & ~ghost_live;
                            eat_n   = 1'b1;
                            eaten_n = eaten_cnt;
                        end
                        // A fresh pellet extends the reversal even on what would have been the expiry tick.
                        if (|pellet_live) begin
                            pellet_n = pellet_on & ~pellet_live;
                            timer_n  = T_FRIGHT;
                        end else if (timer == 10'd0) begin
                            state_n = S_PLAY;
                            ghost_n = 3'b111;
                        end else begin
                            timer_n = timer - 10'd1;
                        end
                    end
                end
                S_DYING: begin
                    if (timer != 10'd0) begin
                        timer_n = timer - 10'd1;
                    end else if (lives == 2'd0) begin
                        state_n = S_OVER;
                        death_n = 1'b1;
                    end else begin
                        state_n   = S_READY;
                        timer_n   = T_READY;
                        lives_n   = lives - 2'd1;
                        respawn_n = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign phase       = state;
    assign reversal    = (state == S_FRIGHT);
    assign fright_left = (state == S_FRIGHT) ? timer : 10'd0;
    assign fright_warn = (state == S_FRIGHT) && (timer < T_WARN);
    assign freeze      = (state != S_PLAY) && (state != S_FRIGHT);

endmodule
